// File: rtl/irq_aggregator_pkg.sv
// Shared constants for the interrupt aggregator: register offsets and ID layout.
package irq_aggregator_pkg;
  localparam int MAX_SOURCES  = 16;
  localparam int ID_VALID_BIT = 4;

  localparam logic [2:0] REG_PENDING   = 3'd0;
  localparam logic [2:0] REG_ENABLE    = 3'd1;
  localparam logic [2:0] REG_EDGE_MODE = 3'd2;
  localparam logic [2:0] REG_ACTIVE    = 3'd3;
  localparam logic [2:0] REG_RAW       = 3'd4;
  localparam logic [2:0] REG_FORCE     = 3'd5;
endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: SYNC_STAGES-deep synchronizer followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic sync,
  output logic rise
);
  logic sync_d;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign sync = src;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] stages;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) stages <= '0;
        else       stages <= (stages << 1) | SYNC_STAGES'(src);
      end
      assign sync = stages[SYNC_STAGES-1];
    end
  endgenerate

  // sync_d resets low so a line held high across reset release gives one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_d <= 1'b0;
    else       sync_d <= sync;
  end

  assign rise = sync & ~sync_d;
endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-source level/edge latching, masking, priority ID and an Avalon-MM register file.
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int                     NUM_SOURCES     = 8,
  parameter int                     SYNC_STAGES     = 2,
  parameter logic [MAX_SOURCES-1:0] EDGE_MODE_RESET = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [2:0]             address,
  input  logic [15:0]            writedata,
  output logic [15:0]            readdata,
  output logic                   irq,
  output logic [4:0]             irq_id
);
  logic                   wr;
  logic [NUM_SOURCES-1:0] wdata;
  logic [NUM_SOURCES-1:0] sync;
  logic [NUM_SOURCES-1:0] rise;
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] enable;
  logic [NUM_SOURCES-1:0] edge_mode;
  logic [NUM_SOURCES-1:0] clr;
  logic [NUM_SOURCES-1:0] frc;
  logic [NUM_SOURCES-1:0] active;
  logic [NUM_SOURCES-1:0] pending_nxt;
  logic [15:0]            rd_mux;

  function automatic logic [MAX_SOURCES-1:0] zext(input logic [NUM_SOURCES-1:0] v);
    zext = '0;
    zext[NUM_SOURCES-1:0] = v;
  endfunction

  // Scan downward so the lowest set index is the last one written.
  function automatic logic [4:0] lowest_id(input logic [NUM_SOURCES-1:0] v);
    lowest_id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_id               = '0;
        lowest_id[ID_VALID_BIT] = 1'b1;
        lowest_id[3:0]          = 4'(i);
      end
    end
  endfunction

  generate
    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
      irq_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync_edge (
        .clk  (clk),
        .reset(reset),
        .src  (irq_src[i]),
        .sync (sync[i]),
        .rise (rise[i])
      );
    end

    if (NUM_SOURCES < MAX_SOURCES) begin : g_wd_unused
      logic unused_wd;
      assign unused_wd = &{1'b0, writedata[MAX_SOURCES-1:NUM_SOURCES]};
    end
  endgenerate

  assign wr     = chipselect & ~write_n;
  assign wdata  = writedata[NUM_SOURCES-1:0];
  assign clr    = (wr && address == REG_PENDING) ? wdata : '0;
  assign frc    = (wr && address == REG_FORCE)   ? wdata : '0;
  assign active = pending & enable;

  // Edge-mode bits: set beats clear. Level-mode bits simply mirror the synchronized line.
  assign pending_nxt = (edge_mode & ((pending & ~clr) | rise | frc)) | (~edge_mode & sync);

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_PENDING:   rd_mux = zext(pending);
      REG_ENABLE:    rd_mux = zext(enable);
      REG_EDGE_MODE: rd_mux = zext(edge_mode);
      REG_ACTIVE:    rd_mux = {11'b0, irq_id};
      REG_RAW:       rd_mux = zext(sync);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      enable    <= '0;
      edge_mode <= EDGE_MODE_RESET[NUM_SOURCES-1:0];
      readdata  <= '0;
      irq       <= 1'b0;
      irq_id    <= '0;
    end else begin
      pending  <= pending_nxt;
      readdata <= rd_mux;
      irq      <= |active;
      irq_id   <= lowest_id(active);
      if (wr && address == REG_ENABLE)    enable    <= wdata;
      if (wr && address == REG_EDGE_MODE) edge_mode <= wdata;
    end
  end
endmodule

// File: tb/tb_irq_aggregator.sv
// Self-checking bench for irq_aggregator: directed scenarios plus randomized bus/source traffic against a reference model.
module tb_irq_aggregator;
  localparam int          NS  = 8;
  localparam int          SS  = 2;
  localparam logic [15:0] EMR = 16'h0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] irq_src;
  logic          chipselect;
  logic          write_n;
  logic [2:0]    address;
  logic [15:0]   writedata;
  logic [15:0]   readdata;
  logic          irq;
  logic [4:0]    irq_id;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  logic [NS-1:0] m_hist[$];
  logic [NS-1:0] m_syncd, m_pend, m_en, m_edge;
  logic          m_irq;
  logic [4:0]    m_id;
  logic [15:0]   m_rd;

  irq_aggregator #(
    .NUM_SOURCES    (NS),
    .SYNC_STAGES    (SS),
    .EDGE_MODE_RESET(EMR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .chipselect(chipselect),
    .write_n   (write_n),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .irq_id    (irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] m_lowest(input logic [NS-1:0] v);
    m_lowest = 5'h00;
    for (int i = 0; i < NS; i++) begin
      if (v[i]) begin
        m_lowest = 5'h10 + 5'(i);
        break;
      end
    end
  endfunction

  task automatic m_reset();
    m_hist.delete();
    m_syncd = '0;
    m_pend  = '0;
    m_en    = '0;
    m_edge  = EMR[NS-1:0];
    m_irq   = 1'b0;
    m_id    = '0;
    m_rd    = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic m_step();
    logic [NS-1:0] s, rise, clr, frc, p_new, active;
    logic          wr;
    int            idx;
    m_hist.push_back(irq_src);
    idx = m_hist.size() - 1 - SS;
    s   = (idx >= 0) ? m_hist[idx] : '0;
    while (m_hist.size() > SS + 1) void'(m_hist.pop_front());
    wr   = chipselect && !write_n;
    clr  = (wr && address == 3'd0) ? writedata[NS-1:0] : '0;
    frc  = (wr && address == 3'd5) ? writedata[NS-1:0] : '0;
    rise = s & ~m_syncd;
    case (address)
      3'd0:    m_rd = 16'(m_pend);
      3'd1:    m_rd = 16'(m_en);
      3'd2:    m_rd = 16'(m_edge);
      3'd3:    m_rd = 16'(m_id);
      3'd4:    m_rd = 16'(s);
      default: m_rd = 16'h0000;
    endcase
    for (int i = 0; i < NS; i++)
      p_new[i] = m_edge[i] ? ((m_pend[i] & ~clr[i]) | rise[i] | frc[i]) : s[i];
    active = m_pend & m_en;
    m_irq  = (active != 0);
    m_id   = m_lowest(active);
    if (wr && address == 3'd1) m_en   = writedata[NS-1:0];
    if (wr && address == 3'd2) m_edge = writedata[NS-1:0];
    m_pend  = p_new;
    m_syncd = s;
  endtask

  task automatic tick();
    if (reset) m_reset();
    else       m_step();
    @(posedge clk);
    @(negedge clk);
    chk("irq", 16'(irq), 16'(m_irq));
    chk("irq_id", 16'(irq_id), 16'(m_id));
    chk("readdata", readdata, m_rd);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic rand_cycle();
    if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ NS'($urandom);
    case ($urandom_range(0, 3))
      0: begin chipselect = 1'b0; write_n = 1'b1; end
      1: begin chipselect = 1'b1; write_n = 1'b0; address = 3'($urandom); writedata = 16'($urandom); end
      2: begin chipselect = 1'b1; write_n = 1'b1; address = 3'($urandom); end
      default: begin chipselect = 1'b0; write_n = 1'b0; address = 3'($urandom); writedata = 16'($urandom); end
    endcase
    tick();
  endtask

  initial begin
    logic [15:0] d;
    reset = 1'b1; irq_src = '0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    m_reset();
    tick(); tick();
    reset = 1'b0;

    // Randomized traffic, then an asynchronous reset in the middle of it
    for (int c = 0; c < 400; c++) rand_cycle();
    chipselect = 1'b0; write_n = 1'b1; irq_src = '0;
    reset = 1'b1;
    #1;
    chk("async_rst_irq", 16'(irq), 16'h0);
    chk("async_rst_id", 16'(irq_id), 16'h0);
    chk("async_rst_rd", readdata, 16'h0);
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), d);
      chk($sformatf("rst_reg%0d", a), d, (a == 2) ? EMR : 16'h0000);
    end
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_id", 16'(irq_id), 16'h0);

    // Edge latch on source 0
    wr_reg(3'd2, 16'h0001);
    wr_reg(3'd1, 16'h0001);
    irq_src = 8'h01; tick();
    irq_src = 8'h00; tick(); tick();
    chk("edge_irq_e2", 16'(irq), 16'h0);
    tick();
    chk("edge_irq_e3", 16'(irq), 16'h1);
    chk("edge_id", 16'(irq_id), 16'h0010);
    rd_reg(3'd0, d);
    chk("edge_pending", d, 16'h0001);
    wr_reg(3'd0, 16'h0001);
    tick();
    chk("edge_w1c_irq", 16'(irq), 16'h0);

    // Level mode on source 2
    wr_reg(3'd2, 16'h0000);
    wr_reg(3'd1, 16'h0004);
    irq_src = 8'h04;
    repeat (4) tick();
    chk("lvl_id", 16'(irq_id), 16'h0012);
    wr_reg(3'd0, 16'h0004);
    tick();
    chk("lvl_w1c_irq", 16'(irq), 16'h1);
    rd_reg(3'd0, d);
    chk("lvl_pending", d, 16'h0004);
    irq_src = 8'h00;
    repeat (3) tick();
    chk("lvl_drop_e2", 16'(irq), 16'h1);
    tick();
    chk("lvl_drop_e3", 16'(irq), 16'h0);

    // Priority and mask with sources 3 and 5
    irq_src = 8'h28;
    wr_reg(3'd1, 16'h0028);
    repeat (4) tick();
    chk("prio_id35", 16'(irq_id), 16'h0013);
    wr_reg(3'd1, 16'h0020);
    chk("prio_id_hold", 16'(irq_id), 16'h0013);
    tick();
    chk("prio_id5", 16'(irq_id), 16'h0015);
    wr_reg(3'd1, 16'h0000);
    tick();
    chk("mask_irq", 16'(irq), 16'h0);
    chk("mask_id", 16'(irq_id), 16'h0);
    irq_src = 8'h00;
    repeat (4) tick();

    // Rise on source 1 landing on the same edge as its W1C
    wr_reg(3'd2, 16'h0002);
    wr_reg(3'd1, 16'h0002);
    irq_src = 8'h02; tick();
    irq_src = 8'h00; repeat (3) tick();
    chk("race_pre_irq", 16'(irq), 16'h1);
    irq_src = 8'h02; tick();
    irq_src = 8'h00; tick();
    wr_reg(3'd0, 16'h0002);
    tick();
    chk("race_irq", 16'(irq), 16'h1);
    rd_reg(3'd0, d);
    chk("race_pending", d, 16'h0002);
    wr_reg(3'd0, 16'h0002);
    tick();
    chk("race_clear_irq", 16'(irq), 16'h0);

    // FORCE, ACTIVE, RAW and unmapped readback
    wr_reg(3'd2, 16'h0080);
    wr_reg(3'd5, 16'h0080);
    rd_reg(3'd0, d);
    chk("force_pending", d, 16'h0080);
    rd_reg(3'd5, d);
    chk("force_read", d, 16'h0000);
    wr_reg(3'd1, 16'h0080);
    tick();
    rd_reg(3'd3, d);
    chk("active_read", d, 16'h0017);
    chk("force_irq", 16'(irq), 16'h1);
    irq_src = 8'h5A;
    tick(); tick();
    rd_reg(3'd4, d);
    chk("raw_read", d, 16'h005A);
    rd_reg(3'd6, d);
    chk("addr6_read", d, 16'h0000);
    rd_reg(3'd7, d);
    chk("addr7_read", d, 16'h0000);

    // More random traffic after the directed scenarios
    for (int c = 0; c < 300; c++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
